// File: rtl/videogen_ctrl_if.sv
// Config request channel for videogen_ctrl: valid/ready handshake carrying run state and pattern.
interface videogen_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_enable;
  logic [2:0] cfg_pattern;

  modport master (output cfg_valid, output cfg_enable, output cfg_pattern, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_enable, input cfg_pattern, output cfg_ready);
endinterface

// File: rtl/videogen_ctrl.sv
// Test-pattern generator sequencer: restarts the generator and applies pattern changes on VSYNC fall.
// Optional auto pattern cycling is built when VIDEOGEN_AUTO_CYCLE_EN is defined.
module videogen_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int NUM_PATTERNS = 4
`ifdef VIDEOGEN_AUTO_CYCLE_EN
  , parameter int AUTO_FRAMES = 120
`endif
) (
  input  logic          clk27,
  input  logic          reset,
  input  logic          vsync_in,
  videogen_ctrl_if.slave cfg,
  output logic          gen_reset_n,
  output logic          gen_enable,
  output logic [2:0]    pattern_sel,
  output logic [15:0]   frame_cnt,
  output logic          timeout_err
);
  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_RESTART = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_PEND    = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state;
  logic             vs_prev;
  logic             ready_q;
  logic [2:0]       req_pat;
  logic [RST_W-1:0] rst_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic       vs_edge, accept, tmo_hit;
  logic [2:0] pat_in;

  assign vs_edge       = vs_prev & ~vsync_in;
  assign accept        = cfg.cfg_valid & ready_q;
  assign tmo_hit       = (tmo_cnt == TMO_LAST);
  assign pat_in        = (32'(cfg.cfg_pattern) < NUM_PATTERNS) ? cfg.cfg_pattern : 3'd0;
  assign cfg.cfg_ready = ready_q;

`ifdef VIDEOGEN_AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
  localparam logic [2:0] PAT_MAX = 3'(NUM_PATTERNS - 1);
  logic [AUTO_W-1:0] auto_cnt;
`endif

  always_ff @(posedge clk27) begin
    if (reset) begin
      state       <= S_OFF;
      gen_reset_n <= 1'b0;
      gen_enable  <= 1'b0;
      pattern_sel <= 3'd0;
      ready_q     <= 1'b1;
      frame_cnt   <= 16'd0;
      timeout_err <= 1'b0;
      vs_prev     <= 1'b1;
      req_pat     <= 3'd0;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
`ifdef VIDEOGEN_AUTO_CYCLE_EN
      auto_cnt    <= '0;
`endif
    end else begin
      vs_prev <= vsync_in;
      if (accept) begin
        req_pat     <= pat_in;
        ready_q     <= 1'b0;
        timeout_err <= 1'b0;
        tmo_cnt     <= '0;
`ifdef VIDEOGEN_AUTO_CYCLE_EN
        auto_cnt    <= '0;
`endif
      end
      if (gen_enable && vs_edge) frame_cnt <= frame_cnt + 16'd1;

      case (state)
        S_OFF: begin
          if (accept && cfg.cfg_enable) begin
            state       <= S_RESTART;
            rst_cnt     <= '0;
            pattern_sel <= pat_in;
            frame_cnt   <= 16'd0;
          end else if (!ready_q) begin
            ready_q <= 1'b1;
          end
        end
        // Generator is stopped here, so no frame boundary to wait for.
        S_RESTART: begin
          if (rst_cnt == RST_LAST) begin
            gen_reset_n <= 1'b1;
            gen_enable  <= 1'b1;
            state       <= S_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            state <= cfg.cfg_enable ? S_PEND : S_STOP;
          end else begin
            if (!ready_q) ready_q <= 1'b1;
`ifdef VIDEOGEN_AUTO_CYCLE_EN
            if (vs_edge) begin
              if (auto_cnt == AUTO_LAST) begin
                pattern_sel <= (pattern_sel >= PAT_MAX) ? 3'd0 : pattern_sel + 3'd1;
                auto_cnt    <= '0;
              end else begin
                auto_cnt <= auto_cnt + 1'b1;
              end
            end
`endif
          end
        end
        // A simultaneous edge and timeout counts as a clean frame-boundary apply.
        S_PEND: begin
          if (vs_edge || tmo_hit) begin
            pattern_sel <= req_pat;
            timeout_err <= ~vs_edge;
            state       <= S_RUN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (vs_edge || tmo_hit) begin
            gen_enable  <= 1'b0;
            gen_reset_n <= 1'b0;
            timeout_err <= ~vs_edge;
            state       <= S_OFF;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end
endmodule

// File: tb/tb_videogen_ctrl.sv
// Directed bench for videogen_ctrl: restart, frame-boundary apply, timeout, clamp, stop, reset.
module tb_videogen_ctrl;
  logic        clk27 = 1'b0;
  logic        reset = 1'b1;
  logic        vsync_in = 1'b1;
  logic        gen_reset_n, gen_enable, timeout_err;
  logic [2:0]  pattern_sel;
  logic [15:0] frame_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  videogen_ctrl_if bus ();

  videogen_ctrl #(
    .RST_CYCLES(4), .TIMEOUT_CYC(40), .NUM_PATTERNS(4)
`ifdef VIDEOGEN_AUTO_CYCLE_EN
    , .AUTO_FRAMES(3)
`endif
  ) dut (
    .clk27(clk27), .reset(reset), .vsync_in(vsync_in), .cfg(bus),
    .gen_reset_n(gen_reset_n), .gen_enable(gen_enable), .pattern_sel(pattern_sel),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk27 = ~clk27;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk27);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic en, input logic [2:0] pat);
    bus.cfg_valid = 1'b1; bus.cfg_enable = en; bus.cfg_pattern = pat;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse();
    vsync_in = 1'b0; tick();
    vsync_in = 1'b1; tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rstn"}, gen_reset_n, 0);
    chk({tag, "_en"}, gen_enable, 0);
    chk({tag, "_pat"}, pattern_sel, 0);
    chk({tag, "_rdy"}, bus.cfg_ready, 1);
    chk({tag, "_fcnt"}, frame_cnt, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_enable = 1'b0; bus.cfg_pattern = 3'd0;
    tick(2);
    reset = 1'b0;
    chk_reset("reset");

    // Start: generator held in reset for 4 cycles, then enabled.
    send(1'b1, 3'd2);
    chk("start_rdy_low", bus.cfg_ready, 0);
    chk("start_pat", pattern_sel, 2);
    tick(3);
    chk("start_rstn_held", gen_reset_n, 0);
    chk("start_en_held", gen_enable, 0);
    tick();
    chk("start_rstn_rel", gen_reset_n, 1);
    chk("start_en", gen_enable, 1);
    chk("start_rdy_still_low", bus.cfg_ready, 0);
    tick();
    chk("start_rdy", bus.cfg_ready, 1);
    chk("start_fcnt", frame_cnt, 0);
    pulse(); pulse();
    chk("fcnt_two", frame_cnt, 2);

    // Mid-frame change waits for VSYNC fall.
    send(1'b1, 3'd1);
    tick(5);
    chk("pend_pat_hold", pattern_sel, 2);
    chk("pend_rdy_low", bus.cfg_ready, 0);
    vsync_in = 1'b0; tick();
    chk("pend_apply", pattern_sel, 1);
    chk("pend_apply_rdy", bus.cfg_ready, 0);
    chk("pend_fcnt", frame_cnt, 3);
    vsync_in = 1'b1; tick();
    chk("pend_rdy_back", bus.cfg_ready, 1);

    // Accept coinciding with the edge is deferred to the next edge.
    vsync_in = 1'b0;
    send(1'b1, 3'd3);
    vsync_in = 1'b1;
    chk("simul_pat_hold", pattern_sel, 1);
    chk("simul_fcnt", frame_cnt, 4);
    tick(3);
    chk("simul_pat_hold2", pattern_sel, 1);
    vsync_in = 1'b0; tick();
    chk("simul_apply", pattern_sel, 3);
    chk("simul_fcnt2", frame_cnt, 5);
    vsync_in = 1'b1; tick();

    // No VSYNC: apply forced after TIMEOUT_CYC cycles.
    send(1'b1, 3'd0);
    tick(39);
    chk("tmo_before", pattern_sel, 3);
    chk("tmo_err_before", timeout_err, 0);
    tick();
    chk("tmo_apply", pattern_sel, 0);
    chk("tmo_err", timeout_err, 1);
    tick();
    chk("tmo_rdy", bus.cfg_ready, 1);
    send(1'b1, 3'd1);
    chk("tmo_clear", timeout_err, 0);
    pulse();
    chk("tmo_next_apply", pattern_sel, 1);

    // Out-of-range pattern clamps to 0.
    send(1'b1, 3'd6);
    pulse();
    chk("clamp_pat", pattern_sel, 0);

    // Stop waits for VSYNC fall.
    send(1'b0, 3'd0);
    tick(2);
    chk("stop_en_hold", gen_enable, 1);
    vsync_in = 1'b0; tick();
    chk("stop_en", gen_enable, 0);
    chk("stop_rstn", gen_reset_n, 0);
    vsync_in = 1'b1; tick();
    chk("stop_rdy", bus.cfg_ready, 1);

    // Disabled request in OFF: ready low for exactly one cycle.
    send(1'b0, 3'd2);
    chk("off_rdy_low", bus.cfg_ready, 0);
    tick();
    chk("off_rdy_back", bus.cfg_ready, 1);
    chk("off_en", gen_enable, 0);

    // Restart with out-of-range code, then move to pattern 3.
    send(1'b1, 3'd7);
    chk("restart_pat", pattern_sel, 0);
    chk("restart_fcnt", frame_cnt, 0);
    tick(5);
    chk("restart_en", gen_enable, 1);
    send(1'b1, 3'd3);
    pulse();
    chk("auto_base", pattern_sel, 3);
    pulse(); pulse();
    chk("auto_two", pattern_sel, 3);
    pulse();
`ifdef VIDEOGEN_AUTO_CYCLE_EN
    chk("auto_wrap", pattern_sel, 0);
`else
    chk("no_auto", pattern_sel, 3);
`endif

    // Reset while a request is pending.
    send(1'b1, 3'd2);
    tick();
    reset = 1'b1; tick();
    chk_reset("midreset");
    reset = 1'b0; tick();
    pulse();
    chk("midreset_dropped", pattern_sel, 0);
    chk("midreset_off", gen_enable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
